// File: rtl/memory_interface_if.sv
// Memory bus bundle between the multicycle core's memory port and the memory.
// The master drives the request side; the slave returns ack and read data.
interface memory_interface_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/memory_interface.sv
// Multicycle-core memory port: selects PC or ALU address, runs one req/ack
// bus transaction per request, owns IR and MDR, formats stores, extends loads
// and stalls the control FSM until the access is over.
module memory_interface #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic        lorD,
    input  logic        ir_write,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] mdr,
    output logic        misaligned,
    output logic        bus_error,
    memory_interface_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] wstrb_f(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    wstrb_f = 4'b0001 << lo;
            SZ_H:    wstrb_f = lo[1] ? 4'b1100 : 4'b0011;
            default: wstrb_f = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] d);
        case (size)
            SZ_B:    wdata_f = {4{d[7:0]}};
            SZ_H:    wdata_f = {2{d[15:0]}};
            default: wdata_f = d;
        endcase
    endfunction

    // Pick the addressed lane from the read word and sign/zero extend it.
    function automatic logic [31:0] load_ext_f(input logic [31:0] rd, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_B:    load_ext_f = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_H:    load_ext_f = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: load_ext_f = rd;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wstrb_q, bus_wstrb_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic        fetch_q, fetch_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lo_q, lo_d;
    logic        stall_s;

    // Request decode: write beats read, a fetch is always a word access,
    // and funct3[1] set (lw and all undefined codes) means a word.
    logic        req_s;
    logic [31:0] addr_s;
    logic [1:0]  size_s;
    logic        fetch_s;
    logic        aligned_s;

    assign req_s     = memory_read | memory_write;
    assign addr_s    = lorD ? alu_out : pc;
    assign fetch_s   = ir_write & ~memory_write;
    assign size_s    = (fetch_s | funct3[1]) ? SZ_W : (funct3[0] ? SZ_H : SZ_B);
    assign aligned_s = (size_s == SZ_B) ? 1'b1 :
                       (size_s == SZ_H) ? ~addr_s[0] : (addr_s[1:0] == 2'b00);

    // Next-state and datapath update for the IDLE/REQ/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        ir_d         = ir_q;
        mdr_d        = mdr_q;
        fetch_d      = fetch_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lo_d         = lo_q;
        stall_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_s = req_s;
                cnt_d   = '0;
                if (req_s) begin
                    fetch_d = fetch_s;
                    size_d  = size_s;
                    uns_d   = funct3[2];
                    lo_d    = addr_s[1:0];
                    if (aligned_s) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = memory_write;
                        bus_addr_d  = {addr_s[31:2], 2'b00};
                        bus_wdata_d = memory_write ? wdata_f(size_s, store_data) : 32'h00000000;
                        bus_wstrb_d = memory_write ? wstrb_f(size_s, addr_s[1:0]) : 4'b0000;
                        state_d     = ST_REQ;
                    end else begin
                        misaligned_d = 1'b1;
                        state_d      = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (bus.bus_ack) begin
                    if (bus_we_q) begin
                        mdr_d = mdr_q;
                    end else if (fetch_q) begin
                        ir_d = bus.bus_rdata;
                    end else begin
                        mdr_d = load_ext_f(bus.bus_rdata, size_q, uns_q, lo_q);
                    end
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    state_d     = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                stall_s = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset wins over
    // any ack arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h00000000;
            bus_wdata_q  <= 32'h00000000;
            bus_wstrb_q  <= 4'b0000;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            ir_q         <= 32'h00000013;
            mdr_q        <= 32'h00000000;
            fetch_q      <= 1'b0;
            size_q       <= SZ_W;
            uns_q        <= 1'b0;
            lo_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            ir_q         <= ir_d;
            mdr_q        <= mdr_d;
            fetch_q      <= fetch_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lo_q         <= lo_d;
        end
    end

    assign stall         = stall_s;
    assign instruction   = ir_q;
    assign mdr           = mdr_q;
    assign misaligned    = misaligned_q;
    assign bus_error     = bus_error_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: fetch, loads, stores, misalignment,
// timeout, stray ack and reset during a transaction.
module tb_memory_interface;

    logic        clk;
    logic        reset;
    logic        memory_read;
    logic        memory_write;
    logic        lorD;
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] mdr;
    logic        misaligned;
    logic        bus_error;

    int n_vec = 0;
    int n_err = 0;

    memory_interface_if bus_if();

    memory_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .lorD         (lorD),
        .ir_write     (ir_write),
        .pc           (pc),
        .alu_out      (alu_out),
        .store_data   (store_data),
        .funct3       (funct3),
        .stall        (stall),
        .instruction  (instruction),
        .mdr          (mdr),
        .misaligned   (misaligned),
        .bus_error    (bus_error),
        .bus          (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no-finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; memory_read = 1'b0; memory_write = 1'b0; lorD = 1'b0;
        ir_write = 1'b0; pc = 32'h0; alu_out = 32'h0; store_data = 32'h0;
        funct3 = 3'b000; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        cyc(); cyc();
        chk("rst_req", bus_if.bus_req, 32'd0);
        chk("rst_we", bus_if.bus_we, 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'h0);
        chk("rst_wstrb", bus_if.bus_wstrb, 32'h0);
        chk("rst_stall", stall, 32'd0);
        chk("rst_ir", instruction, 32'h00000013);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_mis", misaligned, 32'd0);
        chk("rst_err", bus_error, 32'd0);
        reset = 1'b0;
        cyc();

        // Fetch, zero wait state
        pc = 32'h100; memory_read = 1'b1; ir_write = 1'b1; lorD = 1'b0; funct3 = 3'b000;
        #1;
        chk("f_stall_T", stall, 32'd1);
        chk("f_req_T", bus_if.bus_req, 32'd0);
        cyc();
        chk("f_req_T1", bus_if.bus_req, 32'd1);
        chk("f_addr", bus_if.bus_addr, 32'h100);
        chk("f_wstrb", bus_if.bus_wstrb, 32'h0);
        chk("f_we", bus_if.bus_we, 32'd0);
        chk("f_stall_T1", stall, 32'd1);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00500093;
        cyc();
        bus_if.bus_ack = 1'b0; memory_read = 1'b0; ir_write = 1'b0;
        #1;
        chk("f_ir", instruction, 32'h00500093);
        chk("f_stall_T2", stall, 32'd0);
        chk("f_req_T2", bus_if.bus_req, 32'd0);
        cyc();
        chk("f_stall_idle", stall, 32'd0);

        // lb with 3 wait states: ack on the last REQ cycle before timeout
        memory_read = 1'b1; lorD = 1'b1; alu_out = 32'h203; funct3 = 3'b000;
        #1;
        chk("lb_stall_T", stall, 32'd1);
        cyc();
        chk("lb_req", bus_if.bus_req, 32'd1);
        chk("lb_addr", bus_if.bus_addr, 32'h200);
        cyc();
        chk("lb_stall_w1", stall, 32'd1);
        cyc();
        chk("lb_stall_w2", stall, 32'd1);
        chk("lb_req_w2", bus_if.bus_req, 32'd1);
        cyc();
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80FFFFFF;
        chk("lb_stall_w3", stall, 32'd1);
        cyc();
        bus_if.bus_ack = 1'b0; memory_read = 1'b0;
        #1;
        chk("lb_mdr", mdr, 32'hFFFFFF80);
        chk("lb_stall_done", stall, 32'd0);
        chk("lb_err", bus_error, 32'd0);
        chk("lb_ir_keep", instruction, 32'h00500093);
        cyc();

        // lhu upper half, zero wait
        memory_read = 1'b1; lorD = 1'b1; alu_out = 32'h206; funct3 = 3'b101;
        cyc();
        chk("lhu_addr", bus_if.bus_addr, 32'h204);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h80010000;
        cyc();
        bus_if.bus_ack = 1'b0; memory_read = 1'b0;
        #1;
        chk("lhu_mdr", mdr, 32'h00008001);
        cyc();

        // sh upper half
        memory_write = 1'b1; lorD = 1'b1; alu_out = 32'h302; store_data = 32'h0000BEEF;
        funct3 = 3'b001;
        cyc();
        chk("sh_we", bus_if.bus_we, 32'd1);
        chk("sh_addr", bus_if.bus_addr, 32'h300);
        chk("sh_wstrb", bus_if.bus_wstrb, 32'hC);
        chk("sh_wdata", bus_if.bus_wdata, 32'hBEEFBEEF);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
        cyc();
        bus_if.bus_ack = 1'b0; memory_write = 1'b0;
        #1;
        chk("sh_mdr_keep", mdr, 32'h00008001);
        chk("sh_stall_done", stall, 32'd0);
        cyc();

        // sb with read and write both high: write wins
        memory_write = 1'b1; memory_read = 1'b1; alu_out = 32'h301;
        store_data = 32'h123456A5; funct3 = 3'b000;
        cyc();
        chk("sb_we", bus_if.bus_we, 32'd1);
        chk("sb_wstrb", bus_if.bus_wstrb, 32'h2);
        chk("sb_wdata", bus_if.bus_wdata, 32'hA5A5A5A5);
        bus_if.bus_ack = 1'b1;
        cyc();
        bus_if.bus_ack = 1'b0; memory_write = 1'b0; memory_read = 1'b0;
        #1;
        chk("sb_mdr_keep", mdr, 32'h00008001);
        cyc();

        // Misaligned lw
        memory_read = 1'b1; lorD = 1'b1; alu_out = 32'h401; funct3 = 3'b010;
        #1;
        chk("mis_stall_T", stall, 32'd1);
        cyc();
        memory_read = 1'b0;
        #1;
        chk("mis_pulse", misaligned, 32'd1);
        chk("mis_stall_T1", stall, 32'd0);
        chk("mis_req_T1", bus_if.bus_req, 32'd0);
        cyc();
        chk("mis_clear", misaligned, 32'd0);
        chk("mis_req_T2", bus_if.bus_req, 32'd0);

        // Timeout on a fetch with no ack
        memory_read = 1'b1; ir_write = 1'b1; lorD = 1'b0; pc = 32'h500;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("to_req_%0d", i), bus_if.bus_req, 32'd1);
            chk($sformatf("to_err_%0d", i), bus_error, 32'd0);
        end
        cyc();
        memory_read = 1'b0; ir_write = 1'b0;
        #1;
        chk("to_req_drop", bus_if.bus_req, 32'd0);
        chk("to_err", bus_error, 32'd1);
        chk("to_stall", stall, 32'd0);
        chk("to_ir_keep", instruction, 32'h00500093);
        chk("to_mdr_keep", mdr, 32'h00008001);
        // Stray ack while idle must be ignored
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFFFFFF;
        cyc();
        bus_if.bus_ack = 1'b0;
        chk("to_err_clear", bus_error, 32'd0);
        cyc();
        chk("stray_ir", instruction, 32'h00500093);
        chk("stray_mdr", mdr, 32'h00008001);
        chk("stray_req", bus_if.bus_req, 32'd0);

        // Reset during REQ with an ack in the reset cycle
        memory_read = 1'b1; ir_write = 1'b1; pc = 32'h600;
        cyc();
        chk("rr_req", bus_if.bus_req, 32'd1);
        reset = 1'b1; memory_read = 1'b0; ir_write = 1'b0;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
        cyc();
        reset = 1'b0; bus_if.bus_ack = 1'b0;
        #1;
        chk("rr_req_drop", bus_if.bus_req, 32'd0);
        chk("rr_stall", stall, 32'd0);
        chk("rr_ir", instruction, 32'h00000013);
        chk("rr_mdr", mdr, 32'h0);
        cyc();
        chk("rr_idle_req", bus_if.bus_req, 32'd0);
        chk("rr_idle_stall", stall, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
